// File: rtl/div_int_ctrl.sv
// Request/response sequencer for the free-running div_int_u divider: magnitude
// operands in, fixed wait window, signed fixup, divide-by-zero/overflow flags out.
module div_int_ctrl #(
    parameter int WAIT_CYCLES = 130,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_signed,
    input  logic [63:0] req_dnd,
    input  logic [31:0] req_der,
    output logic [63:0] div_dnd,
    output logic [31:0] div_der,
    input  logic [31:0] div_quo,
    input  logic [31:0] div_rem,
    input  logic        div_err,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_quo,
    output logic [31:0] rsp_rem,
    output logic        rsp_dz,
    output logic        rsp_ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dn;
    logic             sn;
    logic             sgn;

    logic             acc_dn;
    logic             acc_sn;
    logic [63:0]      acc_ma;
    logic [31:0]      acc_mb;
    logic             acc_dz;
    logic             acc_pov;

    // The divider's own error flag is superseded by the precheck below.
    logic             unused_err;
    assign unused_err = div_err;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic quo_ovf(input logic ng, input logic is_signed,
                                     input logic [31:0] q);
        return (ng && (q > 32'h8000_0000)) || (!ng && is_signed && q[31]);
    endfunction

    // Magnitudes fit unsigned in the same width, so -2^63 / -2^31 need no extra bit.
    always_comb begin
        acc_dn  = req_signed & req_dnd[63];
        acc_sn  = req_signed & req_der[31];
        acc_ma  = acc_dn ? (~req_dnd + 64'd1) : req_dnd;
        acc_mb  = acc_sn ? (~req_der + 32'd1) : req_der;
        acc_dz  = (acc_mb == 32'd0);
        acc_pov = (acc_ma[63:32] >= acc_mb);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dn        <= 1'b0;
            sn        <= 1'b0;
            sgn       <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_quo   <= 32'd0;
            rsp_rem   <= 32'd0;
            rsp_dz    <= 1'b0;
            rsp_ovf   <= 1'b0;
            div_dnd   <= 64'd0;
            div_der   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        dn        <= acc_dn;
                        sn        <= acc_sn;
                        sgn       <= req_signed;
                        req_ready <= 1'b0;
                        if (acc_dz || acc_pov) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_quo   <= 32'd0;
                            rsp_rem   <= 32'd0;
                            rsp_dz    <= acc_dz;
                            rsp_ovf   <= acc_pov & ~acc_dz;
                        end else begin
                            state   <= RUN;
                            cnt     <= '0;
                            div_dnd <= acc_ma;
                            div_der <= acc_mb;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    // Window long enough for the divider to sample and publish these operands.
                    if (cnt == CNT_W'(WAIT_CYCLES - 1)) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_quo   <= neg_if(dn ^ sn, div_quo);
                        rsp_rem   <= neg_if(dn, div_rem);
                        rsp_dz    <= 1'b0;
                        rsp_ovf   <= quo_ovf(dn ^ sn, sgn, div_quo);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_int_ctrl.sv
// Bench for div_int_ctrl: table of requests with a scoreboard queue, a phased
// model of the free-running divider, plus back-pressure and mid-run reset sequences.
module tb_div_int_ctrl;

    localparam int WAIT = 130;
    localparam int W1   = WAIT + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_signed = 1'b0;
    logic [63:0] req_dnd = 64'd0;
    logic [31:0] req_der = 32'd0;
    logic [63:0] div_dnd;
    logic [31:0] div_der;
    logic [31:0] div_quo = 32'd0;
    logic [31:0] div_rem = 32'd0;
    logic        div_err = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_quo;
    logic [31:0] rsp_rem;
    logic        rsp_dz;
    logic        rsp_ovf;

    always #5 clk = ~clk;

    div_int_ctrl #(.WAIT_CYCLES(WAIT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
        .req_dnd(req_dnd), .req_der(req_der),
        .div_dnd(div_dnd), .div_der(div_der),
        .div_quo(div_quo), .div_rem(div_rem), .div_err(div_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quo(rsp_quo), .rsp_rem(rsp_rem), .rsp_dz(rsp_dz), .rsp_ovf(rsp_ovf)
    );

    // Divider model: samples operands every 64 cycles, publishes 64 cycles later.
    logic [5:0]  ph = 6'd0;
    logic [63:0] s_dnd = 64'd0;
    logic [31:0] s_der = 32'd0;
    logic [63:0] s_q;
    always_comb s_q = (s_der == 32'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : s_dnd / {32'd0, s_der};
    always @(posedge clk) begin
        ph <= ph + 6'd1;
        if (ph == 6'd0) begin
            s_dnd   <= div_dnd;
            s_der   <= div_der;
            div_quo <= s_q[31:0];
            div_rem <= (s_der == 32'd0) ? 32'd0 : 32'(s_dnd % {32'd0, s_der});
            div_err <= (s_der == 32'd0) || (s_q[63:32] != 32'd0);
        end
    end

    typedef struct {
        logic        sgn;
        logic [63:0] dnd;
        logic [31:0] der;
        logic [31:0] quo;
        logic [31:0] rem;
        logic        dz;
        logic        ovf;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] quo;
        logic [31:0] rem;
        logic        dz;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    vec_t        vt[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_ddnd = 64'd0;
    logic [31:0] exp_dder = 32'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mag64(input logic s, input logic [63:0] v);
        return (s && v[63]) ? (~v + 64'd1) : v;
    endfunction

    function automatic logic [31:0] mag32(input logic s, input logic [31:0] v);
        return (s && v[31]) ? (~v + 32'd1) : v;
    endfunction

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_ddnd = 64'd0;
        exp_dder = 32'd0;
    endtask

    task automatic run_req(input vec_t v, input int hold);
        exp_t e;
        int   lat;
        bit   ok;
        req_signed = v.sgn;
        req_dnd    = v.dnd;
        req_der    = v.der;
        req_valid  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!ok) begin
            chk("accept_timeout", 64'd0, 64'd1);
            pulse_reset();
            return;
        end
        e.quo = v.quo; e.rem = v.rem; e.dz = v.dz; e.ovf = v.ovf;
        sb.push_back(e);
        if (v.lat != 1) begin
            exp_ddnd = mag64(v.sgn, v.dnd);
            exp_dder = mag32(v.sgn, v.der);
        end
        lat = 0;
        while (!rsp_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat + 1), 64'(v.lat));
        if (!rsp_valid) begin
            sb.delete();
            pulse_reset();
            return;
        end
        e = sb.pop_front();
        chk("rsp_quo", {32'd0, rsp_quo}, {32'd0, e.quo});
        chk("rsp_rem", {32'd0, rsp_rem}, {32'd0, e.rem});
        chk("rsp_dz", {63'd0, rsp_dz}, {63'd0, e.dz});
        chk("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, e.ovf});
        chk("div_dnd", div_dnd, exp_ddnd);
        chk("div_der", {32'd0, div_der}, {32'd0, exp_dder});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
            chk("hold_ready", {63'd0, req_ready}, 64'd0);
            chk("hold_quo", {32'd0, rsp_quo}, {32'd0, e.quo});
            chk("hold_rem", {32'd0, rsp_rem}, {32'd0, e.rem});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("post_req_ready", {63'd0, req_ready}, 64'd1);
        chk("post_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   ok;

        vt.push_back('{1'b0, 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, W1});
        vt.push_back('{1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, W1});
        vt.push_back('{1'b1, 64'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0, W1});
        vt.push_back('{1'b0, 64'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1});
        vt.push_back('{1'b1, 64'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1});
        vt.push_back('{1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1});
        vt.push_back('{1'b0, 64'h1_0000_0000, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 1});
        vt.push_back('{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b1, 1});
        vt.push_back('{1'b1, 64'hFFFF_FFFF_8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, W1});
        vt.push_back('{1'b1, 64'hFFFF_FFFF_8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, W1});
        vt.push_back('{1'b1, 64'hFFFF_FFFF_7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, W1});
        vt.push_back('{1'b0, 64'h0000_0000_FFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, W1});
        vt.push_back('{1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, W1});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_quo", {32'd0, rsp_quo}, 64'd0);
        chk("rst_rsp_rem", {32'd0, rsp_rem}, 64'd0);
        chk("rst_flags", {62'd0, rsp_dz, rsp_ovf}, 64'd0);
        chk("rst_div_dnd", div_dnd, 64'd0);
        chk("rst_div_der", {32'd0, div_der}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vt[i]) run_req(vt[i], 0);

        // Back-pressure on the first, then a back-to-back second request
        run_req('{1'b0, 64'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, W1}, 10);
        run_req('{1'b0, 64'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 1'b0, W1}, 0);

        // Reset 50 cycles into RUN drops the operation
        req_signed = 1'b0; req_dnd = 64'd100; req_der = 32'd7; req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("abort_accept", {63'd0, ok}, 64'd1);
        repeat (50) @(posedge clk);
        #1;
        chk("abort_running", {62'd0, req_ready, rsp_valid}, 64'd0);
        pulse_reset();
        chk("abort_req_ready", {63'd0, req_ready}, 64'd1);
        chk("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("abort_rsp_quo", {32'd0, rsp_quo}, 64'd0);
        chk("abort_rsp_rem", {32'd0, rsp_rem}, 64'd0);
        chk("abort_flags", {62'd0, rsp_dz, rsp_ovf}, 64'd0);
        chk("abort_div_dnd", div_dnd, 64'd0);
        chk("abort_div_der", {32'd0, div_der}, 64'd0);
        v = '{1'b0, 64'd9, 32'd2, 32'd4, 32'd1, 1'b0, 1'b0, W1};
        run_req(v, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
